// File: rtl/snoop_host_if.sv
// Command/response streams and snoop bus between the host initiator and its environment.
interface snoop_host_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] snoopa;
  logic [7:0]        snoopd;
  logic              snoopm;
  logic              snoopp;
  logic [7:0]        snoopq;
  logic              busy;
  logic              error;

  modport master (
    input  in_data, in_valid, out_ready, snoopq,
    output in_ready, out_data, out_valid, snoopa, snoopd, snoopm, snoopp, busy, error
  );

  modport slave (
    output in_data, in_valid, out_ready, snoopq,
    input  in_ready, out_data, out_valid, snoopa, snoopd, snoopm, snoopp, busy, error
  );
endinterface

// File: rtl/snoop_host.sv
// Byte-stream to snoop-bus initiator: address load, data/program writes, burst reads.
// Optional write readback check is enabled by defining SNOOP_VERIFY_EN.
module snoop_host #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 8
) (
  input logic         clk,
  input logic         reset,
  snoop_host_if.master bus
);

  localparam int unsigned WaitW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  localparam logic [1:0] OpSetAddr = 2'b00;
  localparam logic [1:0] OpWrMem   = 2'b01;
  localparam logic [1:0] OpWrPrg   = 2'b10;

`ifdef SNOOP_VERIFY_EN
  typedef enum logic [3:0] {
    StIdle, StGetAddr, StGetData, StWrStb, StRdAddr, StRdWait, StRdSend, StVfyAddr, StVfyWait
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StWrStb, StRdAddr, StRdWait, StRdSend
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        count_q, count_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] snoopa_q, snoopa_d;
  logic [7:0]        snoopd_q, snoopd_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready;
  logic              in_fire;
  logic              snoopm, snoopp;
`ifdef SNOOP_VERIFY_EN
  logic              error_q, error_d;
`endif

  assign in_fire = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wait_d      = wait_q;
    op_d        = op_q;
    snoopa_d    = snoopa_q;
    snoopd_d    = snoopd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SNOOP_VERIFY_EN
    error_d     = error_q;
`endif
    in_ready    = 1'b0;
    snoopm      = 1'b0;
    snoopp      = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_fire) begin
          op_d = bus.in_data[7:6];
          unique case (bus.in_data[7:6])
            OpSetAddr:        state_d = StGetAddr;
            OpWrMem, OpWrPrg: state_d = StGetData;
            default: begin
              count_d = bus.in_data[5:0];
              state_d = StRdAddr;
            end
          endcase
        end
      end
      StGetAddr: begin
        in_ready = 1'b1;
        if (in_fire) begin
          addr_d  = ADDR_W'(bus.in_data);
          state_d = StIdle;
        end
      end
      StGetData: begin
        in_ready = 1'b1;
        if (in_fire) begin
          snoopd_d = bus.in_data;
          snoopa_d = addr_q;
          state_d  = StWrStb;
        end
      end
      StWrStb: begin
        snoopm = (op_q == OpWrMem);
        snoopp = (op_q == OpWrPrg);
`ifdef SNOOP_VERIFY_EN
        if (op_q == OpWrMem) begin
          state_d = StVfyAddr;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StIdle;
        end
`else
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StIdle;
`endif
      end
      StRdAddr: begin
        snoopa_d = addr_q;
        wait_d   = WaitW'(READ_LAT);
        state_d  = StRdWait;
      end
      StRdWait: begin
        if (wait_q == '0) begin
          out_data_d  = bus.snoopq;
          out_valid_d = 1'b1;
          state_d     = StRdSend;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StRdSend: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          if (count_q == 6'd0) begin
            state_d = StIdle;
          end else begin
            count_d = count_q - 6'd1;
            state_d = StRdAddr;
          end
        end
      end
`ifdef SNOOP_VERIFY_EN
      // snoopa still holds the written address, so only the read latency is waited out.
      StVfyAddr: begin
        wait_d  = WaitW'(READ_LAT);
        state_d = StVfyWait;
      end
      StVfyWait: begin
        if (wait_q == '0) begin
          if (bus.snoopq != snoopd_q) error_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StIdle;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      op_q        <= '0;
      snoopa_q    <= '0;
      snoopd_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef SNOOP_VERIFY_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      op_q        <= op_d;
      snoopa_q    <= snoopa_d;
      snoopd_q    <= snoopd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef SNOOP_VERIFY_EN
      error_q     <= error_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.snoopa    = snoopa_q;
  assign bus.snoopd    = snoopd_q;
  assign bus.snoopm    = snoopm;
  assign bus.snoopp    = snoopp;
  assign bus.busy      = (state_q != StIdle);
`ifdef SNOOP_VERIFY_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_host.sv
// Directed self-checking bench for snoop_host with a registered data-memory model.
module tb_snoop_host;
  localparam int unsigned ReadLat = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  snoop_host_if #(.ADDR_W(8)) bus ();

  snoop_host #(.READ_LAT(ReadLat), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory: one register stage on the read path; address 0x33 reads back corrupted
  // when the readback check is built in.
  logic [7:0] mem [256];
  logic [7:0] q_q;
  logic [7:0] rd_val;
  logic       fill;

  always_comb begin
    rd_val = mem[bus.snoopa];
`ifdef SNOOP_VERIFY_EN
    if (bus.snoopa == 8'h33) rd_val = rd_val ^ 8'h01;
`endif
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.snoopm) begin
      mem[bus.snoopa] <= bus.snoopd;
    end
    q_q <= rd_val;
  end

  assign bus.snoopq = q_q;

  logic [15:0] wm_q[$];
  logic [15:0] wp_q[$];
  int          both_cnt = 0;
  int          long_cnt = 0;
  logic        prev_stb = 1'b0;

  always @(posedge clk) begin
    if (bus.snoopm) wm_q.push_back({bus.snoopa, bus.snoopd});
    if (bus.snoopp) wp_q.push_back({bus.snoopa, bus.snoopd});
    if (bus.snoopm && bus.snoopp) both_cnt++;
    if ((bus.snoopm || bus.snoopp) && prev_stb) long_cnt++;
    prev_stb <= bus.snoopm || bus.snoopp;
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    if (a == 8'h10) return 8'hA5;
    if (a == 8'h11) return 8'h5A;
    return a ^ 8'h5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout byte=%h in_ready never rose", b);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL idle_timeout busy still %b", bus.busy);
    end
  endtask

  task automatic recv(input logic [7:0] exp_d, input logic [7:0] exp_a, input int stall);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rd_wait_in_ready got %b want 0", bus.in_ready);
      end
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL rd_timeout addr=%h out_valid never rose", exp_a);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.snoopa !== exp_a) begin
        errors++;
        $display("FAIL rd_stall got v=%b d=%h a=%h want v=1 d=%h a=%h",
                 bus.out_valid, bus.out_data, bus.snoopa, exp_d, exp_a);
      end
      step();
    end
    checks++;
    if (bus.out_data !== exp_d || bus.snoopa !== exp_a || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_byte got d=%h a=%h rdy=%b want d=%h a=%h rdy=0",
               bus.out_data, bus.snoopa, bus.in_ready, exp_d, exp_a);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.snoopa !== 8'h00 || bus.snoopd !== 8'h00 ||
        bus.snoopm !== 1'b0 || bus.snoopp !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b busy=%b ov=%b od=%h a=%h d=%h m=%b p=%b e=%b want 1 0 0 00 00 00 0 0 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.out_data, bus.snoopa, bus.snoopd,
               bus.snoopm, bus.snoopp, bus.error);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write();
    send(8'h00); send(8'h10); send(8'h40); send(8'hA5);
    checks++;
    if (bus.snoopm !== 1'b1 || bus.snoopp !== 1'b0 || bus.snoopa !== 8'h10 ||
        bus.snoopd !== 8'hA5) begin
      errors++;
      $display("FAIL wr1_strobe got m=%b p=%b a=%h d=%h want m=1 p=0 a=10 d=a5",
               bus.snoopm, bus.snoopp, bus.snoopa, bus.snoopd);
    end
    step();
    checks++;
    if (bus.snoopm !== 1'b0) begin
      errors++;
      $display("FAIL wr1_fall got m=%b want 0", bus.snoopm);
    end
    send(8'h40); send(8'h5A);
    checks++;
    if (bus.snoopm !== 1'b1 || bus.snoopa !== 8'h11 || bus.snoopd !== 8'h5A) begin
      errors++;
      $display("FAIL wr2_strobe got m=%b a=%h d=%h want m=1 a=11 d=5a",
               bus.snoopm, bus.snoopa, bus.snoopd);
    end
    wait_idle();
    checks++;
    if (wm_q.size() != 2 || wp_q.size() != 0) begin
      errors++;
      $display("FAIL wr_count got m=%0d p=%0d want m=2 p=0", wm_q.size(), wp_q.size());
    end else begin
      checks++;
      if (wm_q[0] !== 16'h10A5 || wm_q[1] !== 16'h115A) begin
        errors++;
        $display("FAIL wr_log got %h %h want 10a5 115a", wm_q[0], wm_q[1]);
      end
    end
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL wr_error got %b want 0", bus.error);
    end
  endtask

  task automatic test_prg();
    send(8'h00); send(8'hFF); send(8'h80); send(8'h3C);
    checks++;
    if (bus.snoopp !== 1'b1 || bus.snoopm !== 1'b0 || bus.snoopa !== 8'hFF ||
        bus.snoopd !== 8'h3C) begin
      errors++;
      $display("FAIL prg1_strobe got p=%b m=%b a=%h d=%h want p=1 m=0 a=ff d=3c",
               bus.snoopp, bus.snoopm, bus.snoopa, bus.snoopd);
    end
    send(8'h80); send(8'h77);
    checks++;
    if (bus.snoopp !== 1'b1 || bus.snoopa !== 8'h00 || bus.snoopd !== 8'h77) begin
      errors++;
      $display("FAIL prg2_wrap got p=%b a=%h d=%h want p=1 a=00 d=77",
               bus.snoopp, bus.snoopa, bus.snoopd);
    end
    wait_idle();
    checks++;
    if (wp_q.size() != 2 || wm_q.size() != 2) begin
      errors++;
      $display("FAIL prg_count got p=%0d m=%0d want p=2 m=2", wp_q.size(), wm_q.size());
    end
  endtask

  task automatic test_read();
    send(8'h00); send(8'h10);
    bus.out_ready = 1'b0;
    send(8'hC1);
    for (int i = 0; i < int'(ReadLat) + 2; i++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_latency_early cycle=%0d got ov=%b want 0", i, bus.out_valid);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency got ov=%b want 1", bus.out_valid);
    end
    recv(8'hA5, 8'h10, 5);
    recv(8'h5A, 8'h11, 0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done_busy got %b want 0", bus.busy);
    end
    repeat (4) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_extra_byte got ov=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_read64();
    send(8'h00); send(8'hE0); send(8'hFF);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] a;
      a = 8'hE0 + 8'(i);
      recv(exp_byte(a), a, (i == 0) ? 2 : 0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd64_done got busy=%b rdy=%b want busy=0 rdy=1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(8'h00); send(8'h20); send(8'hC0);
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup got ov=%b want 1", bus.out_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.snoopa !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ov=%b a=%h busy=%b want ov=0 a=00 busy=0",
               bus.out_valid, bus.snoopa, bus.busy);
    end
    reset = 1'b1;
    send(8'h00); send(8'h10); send(8'hC0);
    recv(8'hA5, 8'h10, 0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_resume got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_verify();
    int n = 0;
    send(8'h00); send(8'h33); send(8'h40); send(8'h11);
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
`ifdef SNOOP_VERIFY_EN
    checks++;
    if (n != 3 + int'(ReadLat)) begin
      errors++;
      $display("FAIL vfy_occupancy got %0d want %0d", n, 3 + ReadLat);
    end
    checks++;
    if (bus.error !== 1'b1) begin
      errors++;
      $display("FAIL vfy_error_set got %b want 1", bus.error);
    end
    send(8'h00); send(8'h40); send(8'h40); send(8'h22);
    wait_idle();
    checks++;
    if (bus.error !== 1'b1) begin
      errors++;
      $display("FAIL vfy_error_sticky got %b want 1", bus.error);
    end
`else
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL wr_occupancy got %0d want 1", n);
    end
    send(8'h00); send(8'h40); send(8'h40); send(8'h22);
    wait_idle();
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL error_tied got %b want 0", bus.error);
    end
`endif
    checks++;
    if (wm_q.size() != 4 || wm_q[wm_q.size()-1] !== 16'h4022) begin
      errors++;
      $display("FAIL vfy_wr_log got n=%0d want n=4 last=4022", wm_q.size());
    end
    checks++;
    if (both_cnt != 0 || long_cnt != 0) begin
      errors++;
      $display("FAIL strobe_shape got both=%0d long=%0d want 0 0", both_cnt, long_cnt);
    end
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    fill          = 1'b1;
    step();
    step();
    fill = 1'b0;
    test_reset();
    test_write();
    test_prg();
    test_read();
    test_read64();
    test_reset_mid();
    test_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
